// File: rtl/maxpool_2x2_stream.sv
// rtl/maxpool_2x2_stream.sv - streaming 2x2 stride-2 signed INT8 max-pool with bypass
module maxpool_2x2_stream #(
    parameter int MAX_WIDTH = 416,
    parameter int AW        = $clog2(MAX_WIDTH/2),
    parameter int DIMW      = $clog2(MAX_WIDTH+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIMW-1:0]        cfg_width,
    input  logic [DIMW-1:0]        cfg_height,
    input  logic                   pool_en,
    input  logic signed [7:0]      data_in,
    input  logic                   valid_in,
    output logic signed [7:0]      data_out,
    output logic                   valid_out,
    output logic                   frame_done
);

    logic [DIMW-1:0]   col;
    logic [DIMW-1:0]   row;
    logic [DIMW-1:0]   width_q;
    logic [DIMW-1:0]   height_q;
    logic              pool_q;
    logic signed [7:0] h_hold;
    logic signed [7:0] lb_rdata;
    logic signed [7:0] linebuf [0:MAX_WIDTH/2-1];

    logic              first;
    logic              pool_eff;
    logic [DIMW-1:0]   width_eff;
    logic [DIMW-1:0]   height_eff;
    logic              last_col;
    logic              last_row;
    logic [AW-1:0]     lb_addr;
    logic              lb_we;
    logic              lb_re;
    logic signed [7:0] h_max;
    logic signed [7:0] win_max;

    // Config is live on the first pixel of a frame, then taken from the captured copy.
    always_comb begin
        first      = (col == '0) && (row == '0);
        width_eff  = first ? cfg_width  : width_q;
        height_eff = first ? cfg_height : height_q;
        pool_eff   = first ? pool_en    : pool_q;
        last_col   = (col == width_eff  - DIMW'(1));
        last_row   = (row == height_eff - DIMW'(1));
        lb_addr    = col[AW:1];
        h_max      = (data_in > h_hold) ? data_in : h_hold;
        win_max    = (lb_rdata > h_max) ? lb_rdata : h_max;
        lb_we      = rst_n && valid_in && pool_eff && !row[0] &&  col[0];
        lb_re      = rst_n && valid_in && pool_eff &&  row[0] && !col[0];
    end

    // Writes happen only on even rows and reads only on odd rows, so they never collide.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_addr] <= h_max;
        end
        if (lb_re) begin
            lb_rdata <= linebuf[lb_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            width_q    <= '0;
            height_q   <= '0;
            pool_q     <= 1'b0;
            h_hold     <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                if (first) begin
                    width_q  <= cfg_width;
                    height_q <= cfg_height;
                    pool_q   <= pool_en;
                end
                frame_done <= last_col && last_row;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + DIMW'(1);
                end else begin
                    col <= col + DIMW'(1);
                end
                if (!pool_eff) begin
                    valid_out <= 1'b1;
                    data_out  <= data_in;
                end else if (!col[0]) begin
                    h_hold <= data_in;
                end else if (row[0]) begin
                    valid_out <= 1'b1;
                    data_out  <= win_max;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// tb/tb_maxpool_2x2_stream.sv - randomized self-checking bench for maxpool_2x2_stream
module tb_maxpool_2x2_stream;

    localparam int MAXW = 416;
    localparam int DIMW = $clog2(MAXW+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIMW-1:0]   cfg_width = '0;
    logic [DIMW-1:0]   cfg_height = '0;
    logic              pool_en = 1'b0;
    logic signed [7:0] data_in = '0;
    logic              valid_in = 1'b0;
    logic signed [7:0] data_out;
    logic              valid_out;
    logic              frame_done;

    int checks = 0;
    int passes = 0;
    int last_out = 0;
    int pix [0:1023];
    int obs_q [$];

    maxpool_2x2_stream #(.MAX_WIDTH(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .pool_en(pool_en), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic int smax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Max of the 2x2 window whose bottom-right pixel is (r, c) in a w-wide raster.
    function automatic int window_max(input int w, input int r, input int c);
        return smax(smax(pix[(r-1)*w + c-1], pix[(r-1)*w + c]),
                    smax(pix[r*w + c-1], pix[r*w + c]));
    endfunction

    task automatic idle_cycle();
        valid_in = 1'b0;
        data_in  = 8'($urandom);
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || frame_done !== 1'b0 || data_out !== 8'(last_out))
            $display("FAIL idle: valid_out=%0b frame_done=%0b data_out=%0d required 0 0 %0d",
                     valid_out, frame_done, $signed(data_out), last_out);
        else passes++;
    endtask

    // Drives the first npix pixels of pix[] as a w x h frame and checks every cycle.
    task automatic run_frame(input int w, input int h, input bit pool, input int gap_pct, input int npix);
        int n_out = 0;
        obs_q.delete();
        for (int i = 0; i < npix; i++) begin
            int r = i / w;
            int c = i % w;
            bit exp_v;
            int exp_d;
            bit exp_done;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                int g = $urandom_range(1, 3);
                for (int k = 0; k < g; k++) idle_cycle();
            end
            if (i == 0) begin
                cfg_width  = DIMW'(w);
                cfg_height = DIMW'(h);
                pool_en    = pool;
            end else begin
                cfg_width  = DIMW'($urandom_range(2, MAXW));
                cfg_height = DIMW'($urandom_range(2, MAXW));
                pool_en    = ~pool;
            end
            valid_in = 1'b1;
            data_in  = 8'(pix[i]);
            @(posedge clk); #1;
            exp_v    = !pool || (r % 2 == 1 && c % 2 == 1);
            exp_d    = !pool ? pix[i] : (exp_v ? window_max(w, r, c) : last_out);
            exp_done = (r == h-1) && (c == w-1);
            checks++;
            if (valid_out !== exp_v)
                $display("FAIL valid_out px%0d: got %0b required %0b", i, valid_out, exp_v);
            else passes++;
            checks++;
            if (data_out !== 8'(exp_d))
                $display("FAIL data_out px%0d: got %0d required %0d", i, $signed(data_out), exp_d);
            else passes++;
            checks++;
            if (frame_done !== exp_done)
                $display("FAIL frame_done px%0d: got %0b required %0b", i, frame_done, exp_done);
            else passes++;
            if (valid_out === 1'b1) begin
                n_out++;
                obs_q.push_back(int'(data_out));
            end
            last_out = exp_d;
        end
        if (npix == w*h) begin
            checks++;
            if (n_out !== (pool ? (w/2)*(h/2) : w*h))
                $display("FAIL out_count %0dx%0d: got %0d required %0d", w, h, n_out,
                         pool ? (w/2)*(h/2) : w*h);
            else passes++;
        end
    endtask

    task automatic check_obs(input string name, input int exp_q [$]);
        checks++;
        if (obs_q != exp_q)
            $display("FAIL %s: got %p required %p", name, obs_q, exp_q);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 8'sd0 || frame_done !== 1'b0)
            $display("FAIL reset: valid_out=%0b data_out=%0d frame_done=%0b required 0 0 0",
                     valid_out, $signed(data_out), frame_done);
        else passes++;
        rst_n = 1'b1;
        last_out = 0;
        idle_cycle();
    endtask

    task automatic test_basic_4x4();
        for (int i = 0; i < 16; i++) pix[i] = i;
        run_frame(4, 4, 1'b1, 0, 16);
        check_obs("basic_4x4", '{5, 7, 13, 15});
        idle_cycle();
    endtask

    task automatic test_signed();
        pix[0] = -128; pix[1] = -5; pix[2] = -100; pix[3] = -7;
        run_frame(2, 2, 1'b1, 0, 4);
        check_obs("signed_neg", '{-5});
        for (int i = 0; i < 4; i++) pix[i] = -128;
        run_frame(2, 2, 1'b1, 0, 4);
        check_obs("signed_min", '{-128});
        pix[0] = 127; pix[1] = -128; pix[2] = 0; pix[3] = 1;
        run_frame(2, 2, 1'b1, 0, 4);
        check_obs("signed_mixed", '{127});
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 36; i++) pix[i] = $urandom_range(255) - 128;
            run_frame(6, 6, 1'b1, 0, 36);
        end
        idle_cycle();
    endtask

    task automatic test_odd_dims();
        for (int i = 0; i < 25; i++) pix[i] = i;
        run_frame(5, 5, 1'b1, 0, 25);
        check_obs("odd_5x5", '{6, 8, 16, 18});
        idle_cycle();
    endtask

    task automatic test_gaps_max_width();
        for (int i = 0; i < MAXW*2; i++) pix[i] = $urandom_range(255) - 128;
        run_frame(MAXW, 2, 1'b1, 50, MAXW*2);
        idle_cycle();
    endtask

    task automatic test_bypass_then_pool();
        for (int i = 0; i < 9; i++) pix[i] = 10 + i;
        run_frame(3, 3, 1'b0, 0, 9);
        check_obs("bypass_3x3", '{10, 11, 12, 13, 14, 15, 16, 17, 18});
        for (int i = 0; i < 16; i++) pix[i] = i;
        run_frame(4, 4, 1'b1, 0, 16);
        check_obs("pool_after_bypass", '{5, 7, 13, 15});
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) pix[i] = i;
        run_frame(4, 4, 1'b1, 0, 6);
        rst_n = 1'b0;
        valid_in = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 8'sd0 || frame_done !== 1'b0)
            $display("FAIL reset_mid: valid_out=%0b data_out=%0d frame_done=%0b required 0 0 0",
                     valid_out, $signed(data_out), frame_done);
        else passes++;
        rst_n = 1'b1;
        last_out = 0;
        run_frame(4, 4, 1'b1, 0, 16);
        check_obs("after_reset", '{5, 7, 13, 15});
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            int w = $urandom_range(2, 9);
            int h = $urandom_range(2, 6);
            bit p = ($urandom_range(3) != 0);
            for (int i = 0; i < w*h; i++) pix[i] = $urandom_range(255) - 128;
            run_frame(w, h, p, (k % 3 == 0) ? 30 : 0, w*h);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_signed();
        test_odd_dims();
        test_gaps_max_width();
        test_bypass_then_pool();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2×2, stride-2 signed INT8 max-pooling stage that sits directly downstream of the INT32→INT8 quantizer. It consumes the quantizer's one-pixel-per-cycle raster stream, which has no backpressure, and emits one pooled INT8 pixel per 2×2 window. A single half-width line buffer holds the horizontal maxima of even rows. A bypass mode forwards pixels unchanged for layers without pooling.

## Interface
Parameters:
- MAX_WIDTH, 416: largest supported row width in pixels. Must be even.
- AW, $clog2(MAX_WIDTH/2): line-buffer address width.
- DIMW, $clog2(MAX_WIDTH+1): width of the dimension config ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Synchronous, active-low.
- cfg_width  in  DIMW  input row width in pixels, 2..MAX_WIDTH.
- cfg_height  in  DIMW  input row count, at least 2.
- pool_en  in  1  1 = pool, 0 = bypass.
- data_in  in  8  signed INT8 pixel.
- valid_in  in  1  data_in is valid this cycle.
- data_out  out  8  signed INT8 result.
- valid_out  out  1  data_out is valid this cycle.
- frame_done  out  1  one-cycle pulse with, or after, the last output of a frame.

## Operation
- Config capture: cfg_width, cfg_height and pool_en are sampled on the first valid_in of a frame, i.e. when col=0, row=0. They are ignored for the rest of the frame.
- Counters: col advances on each valid_in and wraps at width-1, which also increments row. A frame ends when row=height-1 and col=width-1 are both consumed; both counters then return to 0.
- Idle cycles: cycles without valid_in leave all state unchanged. Gaps of any length are legal.
- Even row (row[0]=0):
  - Even col: latch data_in into h_hold.
  - Odd col: write signed max(h_hold, data_in) into linebuf[col>>1].
  - No output.
- Odd row, even col: latch data_in into h_hold and issue a synchronous read of linebuf[col>>1].
- Odd row, odd col: output signed max(h_hold, data_in, linebuf_rdata).
- Odd dimensions, floor semantics:
  - Odd width: the last pixel of each row is consumed but discarded, with no linebuf write and no output.
  - Odd height: the last row is consumed with no outputs.
  - Output size is floor(W/2) × floor(H/2).
- Bypass (pool_en=0): every valid input is forwarded. The counters still run, so frame_done still works.
- Compare: all maxima are 8-bit two's complement. -128 < 127.
- Line buffer: MAX_WIDTH/2 × 8 bits, one write port, one registered read port. It can infer block RAM or LUTRAM. A read and a write in the same cycle never hit the same address, because writes occur only on even rows and reads only on odd rows.
- frame_done:
  - If an output accompanies the frame's final consumed pixel, the pulse coincides with that valid_out.
  - Otherwise (odd-height drop, odd-width final pixel), the pulse comes one cycle after the final pixel is consumed.
- Reset mid-frame clears col, row, h_hold and all outputs. The partial frame is abandoned; the next valid_in starts a new frame. Line-buffer contents are not cleared; none are read before being rewritten.

## Timing
- Reset values: data_out=0, valid_out=0, frame_done=0, col=0, row=0.
- Latency:
  - Pool mode: valid_out asserts exactly 1 cycle after the odd-row/odd-col input that completes a window.
  - Bypass mode: valid_out asserts 1 cycle after each valid_in.
- All outputs are registered. data_out holds its last value when valid_out=0.
- Throughput: one input per cycle sustained. In pool mode, at most one output per two inputs.
- No ready/backpressure: the block always accepts valid_in.
- Back-to-back frames with zero gap are supported. The next frame's first pixel may arrive the cycle after the previous frame's last pixel.

## Test plan
- 4×4 frame, pixels 0..15 row-major, pool_en=1 -> outputs 5, 7, 13, 15, each 1 cycle after inputs 5, 7, 13, 15 respectively; frame_done pulses with 15.
- Signed 2×2 window {-128, -5, -100, -7} -> output -5; window of all -128 -> -128; mixed {127, -128, 0, 1} -> 127.
- 5×5 frame (odd width and height), values 0..24 -> exactly 4 outputs: 6, 8, 16, 18; frame_done pulses 1 cycle after pixel 24.
- 416×2 frame, valid_in toggling 1/0 randomly -> 208 outputs matching the golden model; output order and values are unaffected by gaps.
- pool_en=0, 3×3 frame, values 10..18 -> 9 outputs 10..18, each 1 cycle delayed; frame_done pulses with 18. Immediately follow with a pooled 4×4 frame -> correct results.
- Assert rst_n=0 for 1 cycle mid-row of a 4×4 frame -> valid_out, data_out and frame_done are 0 the next cycle. A fresh 4×4 frame afterwards yields 5, 7, 13, 15.
